// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU load/store path and a
// DMA/debug loader. Each access holds the memory strobes for WAIT_CYCLES cycles, then the
// granted port sees a one-cycle ack (plus err if the address was out of range) with its
// registered read data. Ties are broken round-robin; after reset the CPU wins the first tie.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cpu_req/we/addr/wdata       CPU request (held until cpu_ack)
//   cpu_rdata/ack/err           CPU response (rdata held until the next CPU completion)
//   dma_req/we/addr/wdata       DMA request (held until dma_ack)
//   dma_rdata/ack/err           DMA response
//   mem_addr/wdata/write/read   to the memory; all zero outside the access phase
//   mem_rdata                   from the memory (combinational read data)
//   busy                        high whenever an access is in progress

module dmem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 128,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [ADDR_W-1:0] cpu_wdata,
   output logic [ADDR_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_err,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [ADDR_W-1:0] dma_wdata,
   output logic [ADDR_W-1:0] dma_rdata,
   output logic              dma_ack,
   output logic              dma_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [ADDR_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [1:0] stIdle   = 2'd0;
   localparam logic [1:0] stAccess = 2'd1;
   localparam logic [1:0] stDone   = 2'd2;

   // Range check is done on the full address width, one bit wider to hold DEPTH itself.
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   logic [1:0]        state;
   logic              lastGrant;   // 1 = DMA was granted last
   logic              grantDma;
   logic              reqWe;
   logic              reqOor;
   logic [ADDR_W-1:0] reqAddr;
   logic [ADDR_W-1:0] reqWdata;
   logic [ADDR_W-1:0] cpuRdataQ;
   logic [ADDR_W-1:0] dmaRdataQ;
   logic [3:0]        waitCnt;

   logic              pickDma;
   logic [ADDR_W-1:0] selAddr;
   logic              selOor;
   logic [ADDR_W-1:0] captured;

   always_comb begin
      // DMA wins when it is the only requester, or on a tie when the CPU went last.
      pickDma  = dma_req & (~cpu_req | ~lastGrant);
      selAddr  = pickDma ? dma_addr : cpu_addr;
      selOor   = ({1'b0, selAddr} >= DEPTH_EXT);
      captured = (reqWe | reqOor) ? '0 : mem_rdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= stIdle;
         lastGrant <= 1'b1;
         grantDma  <= 1'b0;
         reqWe     <= 1'b0;
         reqOor    <= 1'b0;
         reqAddr   <= '0;
         reqWdata  <= '0;
         cpuRdataQ <= '0;
         dmaRdataQ <= '0;
         waitCnt   <= '0;
      end else begin
         case (state)
            stIdle: begin
               if (cpu_req || dma_req) begin
                  grantDma  <= pickDma;
                  lastGrant <= pickDma;
                  reqWe     <= pickDma ? dma_we : cpu_we;
                  reqAddr   <= selAddr;
                  reqWdata  <= pickDma ? dma_wdata : cpu_wdata;
                  reqOor    <= selOor;
                  waitCnt   <= WAIT_LOAD;
                  state     <= stAccess;
               end
            end
            stAccess: begin
               if (waitCnt == 4'd0) begin
                  if (grantDma) begin
                     dmaRdataQ <= captured;
                  end else begin
                     cpuRdataQ <= captured;
                  end
                  state <= stDone;
               end else begin
                  waitCnt <= waitCnt - 4'd1;
               end
            end
            stDone: begin
               state <= stIdle;
            end
            default: begin
               state <= stIdle;
            end
         endcase
      end
   end

   logic inAccess;
   logic inDone;

   always_comb begin
      inAccess  = (state == stAccess);
      inDone    = (state == stDone);
      busy      = (state != stIdle);
      mem_addr  = inAccess ? reqAddr : '0;
      mem_wdata = inAccess ? reqWdata : '0;
      mem_write = inAccess & reqWe & ~reqOor;
      mem_read  = inAccess & ~reqWe & ~reqOor;
      cpu_ack   = inDone & ~grantDma;
      cpu_err   = inDone & ~grantDma & reqOor;
      dma_ack   = inDone & grantDma;
      dma_err   = inDone & grantDma & reqOor;
      cpu_rdata = cpuRdataQ;
      dma_rdata = dmaRdataQ;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (WAIT_CYCLES 1 and 3) exercised one after the other
// by directed scenarios and random traffic, checked cycle by cycle against a transaction model.
module tb_dmem_arbiter;

   localparam int          DEPTH   = 128;
   localparam logic [31:0] DEPTH_L = 32'd128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int   curD;
   logic dRst;
   logic memInit;
   logic dReq[2];
   logic dWe[2];
   logic [31:0] dAddr[2];
   logic [31:0] dWdata[2];

   logic        oBusy[2], oWr[2], oRd[2], oCAck[2], oCErr[2], oDAck[2], oDErr[2];
   logic [31:0] oAddr[2], oWd[2], oCRd[2], oDRd[2];

   function automatic logic [31:0] initVal(input int i);
      logic [31:0] v;
      v = 32'(i);
      return (v * 32'h9E3779B9) ^ 32'h5A5A0000;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gDut
      logic [31:0] envMem [DEPTH];
      logic [31:0] memRd;

      assign memRd = (oAddr[g] < DEPTH_L) ? envMem[oAddr[g][6:0]] : 32'hBAD0BAD0;

      always @(posedge clk) begin
         if (memInit) begin
            for (int i = 0; i < DEPTH; i++) envMem[i] <= initVal(i);
         end else if (oWr[g] && oAddr[g] < DEPTH_L) begin
            envMem[oAddr[g][6:0]] <= oWd[g];
         end
      end

      dmem_arbiter #(
         .ADDR_W     (32),
         .DEPTH      (DEPTH),
         .WAIT_CYCLES(g == 0 ? 1 : 3)
      ) dut (
         .clk      (clk),
         .rst      ((curD != g) || dRst),
         .cpu_req  ((curD == g) ? dReq[0] : 1'b0),
         .cpu_we   (dWe[0]),
         .cpu_addr (dAddr[0]),
         .cpu_wdata(dWdata[0]),
         .cpu_rdata(oCRd[g]),
         .cpu_ack  (oCAck[g]),
         .cpu_err  (oCErr[g]),
         .dma_req  ((curD == g) ? dReq[1] : 1'b0),
         .dma_we   (dWe[1]),
         .dma_addr (dAddr[1]),
         .dma_wdata(dWdata[1]),
         .dma_rdata(oDRd[g]),
         .dma_ack  (oDAck[g]),
         .dma_err  (oDErr[g]),
         .mem_addr (oAddr[g]),
         .mem_wdata(oWd[g]),
         .mem_write(oWr[g]),
         .mem_read (oRd[g]),
         .mem_rdata(memRd),
         .busy     (oBusy[g])
      );
   end

   int nCmp = 0;
   int nBad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s dut=%0d t=%0t got=%h exp=%h", tag, curD, $time, got, exp);
      end
   endtask

   // Transaction model: a grant at the end of an idle cycle puts strobes in the next W cycles
   // and the ack in the one after that; the slot frees one cycle later.
   int          W;
   int          cyc;
   bit          mActive;
   int          mPhase;
   bit          mPort;
   bit          mWe;
   bit          mOor;
   bit          mLast;
   logic [31:0] mAddr, mWdata;
   logic [31:0] mRdata[2];
   logic [31:0] shadow[DEPTH];
   bit          eAck[2];
   bit          randMode;
   bit          keepHigh;
   int          ackPort[$];
   int          ackCyc[$];

   task automatic modelAdvance();
      cyc++;
      if (dRst) begin
         // The memory still sees a write strobe that was high on the reset edge.
         if (mActive && mPhase <= W && mWe && !mOor) shadow[mAddr[6:0]] = mWdata;
         mActive   = 1'b0;
         mLast     = 1'b1;
         mRdata[0] = '0;
         mRdata[1] = '0;
      end else if (mActive) begin
         if (mPhase == W + 1) begin
            mActive = 1'b0;
         end else begin
            if (mWe && !mOor) shadow[mAddr[6:0]] = mWdata;
            mPhase++;
            if (mPhase == W + 1) mRdata[mPort] = (mWe || mOor) ? 32'h0 : shadow[mAddr[6:0]];
         end
      end else if (dReq[0] || dReq[1]) begin
         mPort   = (dReq[0] && dReq[1]) ? !mLast : dReq[1];
         mLast   = mPort;
         mWe     = dWe[mPort];
         mAddr   = dAddr[mPort];
         mWdata  = dWdata[mPort];
         mOor    = (mAddr >= DEPTH_L);
         mActive = 1'b1;
         mPhase  = 1;
      end
   endtask

   task automatic checkOutputs();
      logic        eBusy, eW, eR;
      logic [31:0] eAddr, eWd;
      bit          eErr[2];
      eBusy = 0; eW = 0; eR = 0; eAddr = '0; eWd = '0;
      eAck[0] = 0; eAck[1] = 0; eErr[0] = 0; eErr[1] = 0;
      if (mActive) begin
         eBusy = 1;
         if (mPhase <= W) begin
            eAddr = mAddr;
            eWd   = mWdata;
            eW    = mWe & !mOor;
            eR    = !mWe & !mOor;
         end else begin
            eAck[mPort] = 1;
            eErr[mPort] = mOor;
         end
      end
      check("busy", oBusy[curD], eBusy);
      check("mem_write", oWr[curD], eW);
      check("mem_read", oRd[curD], eR);
      check("mem_addr", oAddr[curD], eAddr);
      check("mem_wdata", oWd[curD], eWd);
      check("cpu_ack", oCAck[curD], eAck[0]);
      check("cpu_err", oCErr[curD], eErr[0]);
      check("dma_ack", oDAck[curD], eAck[1]);
      check("dma_err", oDErr[curD], eErr[1]);
      check("cpu_rdata", oCRd[curD], mRdata[0]);
      check("dma_rdata", oDRd[curD], mRdata[1]);
      if (oCAck[curD]) begin ackPort.push_back(0); ackCyc.push_back(cyc); end
      if (oDAck[curD]) begin ackPort.push_back(1); ackCyc.push_back(cyc); end
   endtask

   function automatic logic [31:0] randAddr();
      case ($urandom % 8)
         5:       return 32'd127 + ($urandom % 2);
         6:       return 32'd129 + ($urandom % 72);
         7:       return 32'h80000000 | ($urandom % 128);
         default: return $urandom % 128;
      endcase
   endfunction

   task automatic newReq(input int p);
      dReq[p]   = 1'b1;
      dWe[p]    = 1'($urandom % 2);
      dAddr[p]  = randAddr();
      dWdata[p] = $urandom;
   endtask

   task automatic driveStep();
      for (int p = 0; p < 2; p++) begin
         if (eAck[p]) begin
            if (randMode ? ($urandom % 2 == 0) : keepHigh) begin
               if (randMode) newReq(p);
            end else begin
               dReq[p] = 1'b0;
            end
         end else if (randMode) begin
            if (!dReq[p]) begin
               if ($urandom % 3 == 0) newReq(p);
            end else if (mActive && mPort == p && mPhase <= W && $urandom % 3 == 0) begin
               // Already latched: these changes must not reach the memory.
               dWe[p]    = 1'($urandom % 2);
               dAddr[p]  = randAddr();
               dWdata[p] = $urandom;
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      modelAdvance();
      @(negedge clk);
      checkOutputs();
      driveStep();
   endtask

   task automatic setReq(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] wd);
      dReq[p]   = 1'b1;
      dWe[p]    = we;
      dAddr[p]  = a;
      dWdata[p] = wd;
   endtask

   task automatic resetModel();
      for (int i = 0; i < DEPTH; i++) shadow[i] = initVal(i);
   endtask

   initial begin
      int nRead, nWrite, nBusy, ackAt, errAt;
      curD = 0; W = 1; cyc = 0;
      dRst = 1'b1; memInit = 1'b1;
      randMode = 0; keepHigh = 0;
      mActive = 0; mPhase = 0; mLast = 1; mRdata[0] = '0; mRdata[1] = '0;
      for (int p = 0; p < 2; p++) begin
         dReq[p] = 0; dWe[p] = 0; dAddr[p] = '0; dWdata[p] = '0;
      end
      resetModel();
      repeat (3) cycle();
      memInit = 1'b0;
      dRst    = 1'b0;
      repeat (2) cycle();

      // CPU write then read back at address 5.
      setReq(0, 1'b1, 32'd5, 32'hDEADBEEF);
      ackPort.delete(); ackCyc.delete();
      repeat (4) cycle();
      check("wr5_acks", ackPort.size(), 1);
      setReq(0, 1'b0, 32'd5, 32'h0);
      repeat (4) cycle();
      check("rd5_rdata", oCRd[curD], 32'hDEADBEEF);
      repeat (2) cycle();
      check("rd5_rdata_held", oCRd[curD], 32'hDEADBEEF);

      // Fresh reset, then a held tie: CPU, DMA, CPU, DMA, three cycles apart.
      dRst = 1'b1;
      repeat (2) cycle();
      dRst = 1'b0;
      keepHigh = 1;
      setReq(0, 1'b1, 32'd10, 32'h11110000);
      setReq(1, 1'b1, 32'd11, 32'h22220000);
      ackPort.delete(); ackCyc.delete();
      for (int i = 0; i < 40 && ackPort.size() < 4; i++) cycle();
      keepHigh = 0;
      dReq[0] = 0; dReq[1] = 0;
      check("tie_ack_count", ackPort.size(), 4);
      for (int k = 0; k < ackPort.size() && k < 4; k++) begin
         check("tie_order", ackPort[k], k % 2);
         if (k > 0) check("tie_spacing", ackCyc[k] - ackCyc[k-1], 3);
      end
      repeat (3) cycle();

      // Reset during the access phase of a CPU write (CPU was granted last).
      setReq(0, 1'b1, 32'd20, 32'hCAFEF00D);
      cycle();
      check("rst_pre_write", oWr[curD], 1'b1);
      dRst = 1'b1;
      cycle();
      check("rst_write_low", oWr[curD], 1'b0);
      check("rst_busy_low", oBusy[curD], 1'b0);
      check("rst_no_ack", oCAck[curD], 1'b0);
      dRst = 1'b0;
      setReq(0, 1'b0, 32'd21, 32'h0);
      setReq(1, 1'b0, 32'd22, 32'h0);
      ackPort.delete(); ackCyc.delete();
      for (int i = 0; i < 10 && ackPort.size() < 1; i++) cycle();
      check("rst_tie_acks", ackPort.size(), 1);
      if (ackPort.size() > 0) check("rst_tie_cpu_first", ackPort[0], 0);
      repeat (6) cycle();

      randMode = 1;
      repeat (1500) cycle();
      randMode = 0;
      dReq[0] = 0; dReq[1] = 0;
      repeat (8) cycle();

      // Second instance, WAIT_CYCLES = 3.
      curD = 1; W = 3;
      dRst = 1'b1;
      resetModel();
      repeat (2) cycle();
      dRst = 1'b0;
      cycle();

      setReq(1, 1'b0, 32'd127, 32'h0);
      nRead = 0; nBusy = 0; ackAt = 0;
      for (int i = 1; i <= 7; i++) begin
         cycle();
         if (oRd[curD]) nRead++;
         if (oBusy[curD]) nBusy++;
         if (oDAck[curD]) ackAt = i;
      end
      check("w3_read_cycles", nRead, 3);
      check("w3_busy_cycles", nBusy, 4);
      check("w3_ack_cycle", ackAt, 4);
      check("w3_rdata127", oDRd[curD], initVal(127));

      setReq(1, 1'b1, 32'd128, 32'h12345678);
      nWrite = 0; ackAt = 0; errAt = 0;
      for (int i = 1; i <= 7; i++) begin
         cycle();
         if (oWr[curD]) nWrite++;
         if (oDAck[curD]) ackAt = i;
         if (oDErr[curD]) errAt = i;
      end
      check("oor_no_write", nWrite, 0);
      check("oor_ack_cycle", ackAt, 4);
      check("oor_err_cycle", errAt, 4);
      check("oor_rdata_zero", oDRd[curD], 32'h0);

      randMode = 1;
      repeat (1500) cycle();
      randMode = 0;
      dReq[0] = 0; dReq[1] = 0;
      repeat (8) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
